// File: rtl/conv_layer_sched.sv
// Layer sequencer for CONV_ACC: queues layer descriptors, configures and starts the kernel,
// generates IFM/weight read addresses, checks beat counts and reports per-layer status.
module conv_layer_sched #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned IFM_UNIT = 7904,
  parameter int unsigned WGT_UNIT = 13312,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_ci_i,
  input  logic [1:0]        cmd_co_i,
  input  logic [ADDR_W-1:0] cmd_ifm_base_i,
  input  logic [ADDR_W-1:0] cmd_wgt_base_i,
  output logic [1:0]        cfg_ci_o,
  output logic [1:0]        cfg_co_o,
  output logic              start_conv_o,
  input  logic              ifm_read_i,
  input  logic              wgt_read_i,
  input  logic              end_conv_i,
  input  logic              ofm_port0_v_i,
  input  logic              ofm_port1_v_i,
  output logic [ADDR_W-1:0] ifm_addr_o,
  output logic [ADDR_W-1:0] wgt_addr_o,
  output logic              busy_o,
  output logic              done_valid_o,
  output logic [2:0]        done_status_o,
  output logic [23:0]       done_ofm_cnt_o
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned OFM_W = 24;
  localparam int unsigned SUM_W = OFM_W + 1;
  localparam int unsigned WD_W  = 16;
  localparam int unsigned DEPTH = 2;

  typedef struct packed {
    logic [1:0]        ci;
    logic [1:0]        co;
    logic [ADDR_W-1:0] ifm_base;
    logic [ADDR_W-1:0] wgt_base;
  } desc_t;

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_START, S_RUN, S_DONE} state_e;

  state_e            state_q, state_d;
  desc_t             fifo_q [DEPTH];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;
  logic              push, pop;
  desc_t             head;

  logic [1:0]        ci_q, ci_d, co_q, co_d;
  logic [CNT_W-1:0]  ifm_exp_q, ifm_exp_d, wgt_exp_q, wgt_exp_d;
  logic [CNT_W-1:0]  ifm_cnt_q, ifm_cnt_d, wgt_cnt_q, wgt_cnt_d;
  logic [ADDR_W-1:0] ifm_addr_q, ifm_addr_d, wgt_addr_q, wgt_addr_d;
  logic [OFM_W-1:0]  ofm_cnt_q, ofm_cnt_d;
  logic [SUM_W-1:0]  ofm_sum;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              ifm_err_q, ifm_err_d, wgt_err_q, wgt_err_d;
  logic              activity, timeout_hit;
  logic              start_q, start_d;
  logic              done_valid_q, done_valid_d;
  logic [2:0]        done_status_q, done_status_d;
  logic [OFM_W-1:0]  done_ofm_q, done_ofm_d;
  logic              busy_q, busy_d;
  logic              cmd_ready_q, cmd_ready_d;

  assign push = cmd_valid_i && cmd_ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != 2'd0);
  assign head = fifo_q[rd_ptr_q];

  // Descriptor FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{ci: cmd_ci_i, co: cmd_co_i,
                              ifm_base: cmd_ifm_base_i, wgt_base: cmd_wgt_base_i};
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      ci_q          <= '0;
      co_q          <= '0;
      ifm_exp_q     <= '0;
      wgt_exp_q     <= '0;
      ifm_cnt_q     <= '0;
      wgt_cnt_q     <= '0;
      ifm_addr_q    <= '0;
      wgt_addr_q    <= '0;
      ofm_cnt_q     <= '0;
      wd_q          <= '0;
      ifm_err_q     <= 1'b0;
      wgt_err_q     <= 1'b0;
      start_q       <= 1'b0;
      done_valid_q  <= 1'b0;
      done_status_q <= '0;
      done_ofm_q    <= '0;
      busy_q        <= 1'b0;
      cmd_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      ci_q          <= ci_d;
      co_q          <= co_d;
      ifm_exp_q     <= ifm_exp_d;
      wgt_exp_q     <= wgt_exp_d;
      ifm_cnt_q     <= ifm_cnt_d;
      wgt_cnt_q     <= wgt_cnt_d;
      ifm_addr_q    <= ifm_addr_d;
      wgt_addr_q    <= wgt_addr_d;
      ofm_cnt_q     <= ofm_cnt_d;
      wd_q          <= wd_d;
      ifm_err_q     <= ifm_err_d;
      wgt_err_q     <= wgt_err_d;
      start_q       <= start_d;
      done_valid_q  <= done_valid_d;
      done_status_q <= done_status_d;
      done_ofm_q    <= done_ofm_d;
      busy_q        <= busy_d;
      cmd_ready_q   <= cmd_ready_d;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    state_d       = state_q;
    ci_d          = ci_q;
    co_d          = co_q;
    ifm_exp_d     = ifm_exp_q;
    wgt_exp_d     = wgt_exp_q;
    ifm_cnt_d     = ifm_cnt_q;
    wgt_cnt_d     = wgt_cnt_q;
    ifm_addr_d    = ifm_addr_q;
    wgt_addr_d    = wgt_addr_q;
    ofm_cnt_d     = ofm_cnt_q;
    wd_d          = wd_q;
    ifm_err_d     = ifm_err_q;
    wgt_err_d     = wgt_err_q;
    start_d       = 1'b0;
    done_valid_d  = 1'b0;
    done_status_d = done_status_q;
    done_ofm_d    = done_ofm_q;
    activity      = ifm_read_i || wgt_read_i || ofm_port0_v_i || ofm_port1_v_i;
    timeout_hit   = 1'b0;
    ofm_sum       = SUM_W'(ofm_cnt_q) + SUM_W'(ofm_port0_v_i) + SUM_W'(ofm_port1_v_i);

    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (count_q != 2'd0) begin
          state_d    = S_CFG;
          ci_d       = head.ci;
          co_d       = head.co;
          ifm_exp_d  = CNT_W'(IFM_UNIT) * (CNT_W'(head.ci) + CNT_W'(1));
          wgt_exp_d  = CNT_W'(WGT_UNIT) * (CNT_W'(head.ci) + CNT_W'(1))
                                        * (CNT_W'(head.co) + CNT_W'(1));
          ifm_addr_d = head.ifm_base;
          wgt_addr_d = head.wgt_base;
          ifm_cnt_d  = '0;
          wgt_cnt_d  = '0;
          ofm_cnt_d  = '0;
          wd_d       = '0;
          ifm_err_d  = 1'b0;
          wgt_err_d  = 1'b0;
        end
      end
      S_CFG: begin
        state_d = S_START;
        start_d = 1'b1;
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (ifm_read_i) begin
          ifm_addr_d = ifm_addr_q + ADDR_W'(8);
          ifm_cnt_d  = ifm_cnt_q + CNT_W'(1);
          if (ifm_cnt_q == ifm_exp_q) ifm_err_d = 1'b1;
        end
        if (wgt_read_i) begin
          wgt_addr_d = wgt_addr_q + ADDR_W'(4);
          wgt_cnt_d  = wgt_cnt_q + CNT_W'(1);
          if (wgt_cnt_q == wgt_exp_q) wgt_err_d = 1'b1;
        end
        ofm_cnt_d   = ofm_sum[OFM_W] ? '1 : ofm_sum[OFM_W-1:0];
        wd_d        = activity ? '0 : wd_q + WD_W'(1);
        timeout_hit = !activity && (wd_q == WD_W'(TIMEOUT - 1));
        // end_conv wins over a coincident watchdog expiry
        if (end_conv_i || timeout_hit) begin
          state_d       = S_DONE;
          done_valid_d  = 1'b1;
          done_status_d = {timeout_hit && !end_conv_i,
                           wgt_err_d || (wgt_cnt_d != wgt_exp_q),
                           ifm_err_d || (ifm_cnt_d != ifm_exp_q)};
          done_ofm_d    = ofm_cnt_d;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (count_d != 2'd2);
    busy_d      = (state_d != S_IDLE) || (count_d != 2'd0);
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign cfg_ci_o       = ci_q;
  assign cfg_co_o       = co_q;
  assign start_conv_o   = start_q;
  assign ifm_addr_o     = ifm_addr_q;
  assign wgt_addr_o     = wgt_addr_q;
  assign busy_o         = busy_q;
  assign done_valid_o   = done_valid_q;
  assign done_status_o  = done_status_q;
  assign done_ofm_cnt_o = done_ofm_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: single layer, overrun/underrun, timeout,
// back-to-back with a full FIFO, and reset in the middle of a layer.
module tb_conv_layer_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_ci_i = '0, cmd_co_i = '0;
  logic [31:0] cmd_ifm_base_i = '0, cmd_wgt_base_i = '0;
  logic [1:0]  cfg_ci_o, cfg_co_o;
  logic        start_conv_o;
  logic        ifm_read_i = 1'b0, wgt_read_i = 1'b0, end_conv_i = 1'b0;
  logic        ofm_port0_v_i = 1'b0, ofm_port1_v_i = 1'b0;
  logic [31:0] ifm_addr_o, wgt_addr_o;
  logic        busy_o, done_valid_o;
  logic [2:0]  done_status_o;
  logic [23:0] done_ofm_cnt_o;

  int total = 0;
  int bad   = 0;
  int early;
  int k;

  always #5 clk = ~clk;

  conv_layer_sched #(
    .ADDR_W(32), .IFM_UNIT(7904), .WGT_UNIT(13312), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_ci_i(cmd_ci_i), .cmd_co_i(cmd_co_i),
    .cmd_ifm_base_i(cmd_ifm_base_i), .cmd_wgt_base_i(cmd_wgt_base_i),
    .cfg_ci_o(cfg_ci_o), .cfg_co_o(cfg_co_o), .start_conv_o(start_conv_o),
    .ifm_read_i(ifm_read_i), .wgt_read_i(wgt_read_i), .end_conv_i(end_conv_i),
    .ofm_port0_v_i(ofm_port0_v_i), .ofm_port1_v_i(ofm_port1_v_i),
    .ifm_addr_o(ifm_addr_o), .wgt_addr_o(wgt_addr_o), .busy_o(busy_o),
    .done_valid_o(done_valid_o), .done_status_o(done_status_o),
    .done_ofm_cnt_o(done_ofm_cnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [1:0] ci, input logic [1:0] co,
                         input logic [31:0] ib, input logic [31:0] wb);
    cmd_valid_i    = 1'b1;
    cmd_ci_i       = ci;
    cmd_co_i       = co;
    cmd_ifm_base_i = ib;
    cmd_wgt_base_i = wb;
  endtask

  // Kernel model: strobes for the given beat counts, then one end_conv cycle.
  task automatic run_kernel(input int n_ifm, input int n_wgt, input int n_o0,
                            input int n_o1, output int unexpected);
    int n;
    n = n_ifm;
    if (n_wgt > n) n = n_wgt;
    if (n_o0 > n) n = n_o0;
    if (n_o1 > n) n = n_o1;
    unexpected = 0;
    for (int i = 0; i < n; i++) begin
      ifm_read_i    = (i < n_ifm);
      wgt_read_i    = (i < n_wgt);
      ofm_port0_v_i = (i < n_o0);
      ofm_port1_v_i = (i < n_o1);
      tick();
      if (done_valid_o || start_conv_o) unexpected++;
    end
    ifm_read_i    = 1'b0;
    wgt_read_i    = 1'b0;
    ofm_port0_v_i = 1'b0;
    ofm_port1_v_i = 1'b0;
    end_conv_i    = 1'b1;
    tick();
    end_conv_i    = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL global_timeout: observed=hang expected=finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_start", 64'(start_conv_o), 64'd0);
    chk("rst_done_valid", 64'(done_valid_o), 64'd0);
    chk("rst_ifm_addr", 64'(ifm_addr_o), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", 64'(cmd_ready_o), 64'd1);
    chk("busy_after_rst", 64'(busy_o), 64'd0);

    // Single layer ci=0 co=0
    set_cmd(2'd0, 2'd0, 32'h1000, 32'h8000);
    tick();
    cmd_valid_i = 1'b0;
    chk("l1_busy_queued", 64'(busy_o), 64'd1);
    chk("l1_start_e0", 64'(start_conv_o), 64'd0);
    tick();
    chk("l1_start_cfg", 64'(start_conv_o), 64'd0);
    chk("l1_ifm_base", 64'(ifm_addr_o), 64'h1000);
    chk("l1_wgt_base", 64'(wgt_addr_o), 64'h8000);
    tick();
    chk("l1_start_pulse", 64'(start_conv_o), 64'd1);
    tick();
    chk("l1_start_low", 64'(start_conv_o), 64'd0);
    run_kernel(7904, 13312, 10, 4, early);
    chk("l1_no_early", 64'(early), 64'd0);
    chk("l1_done_valid", 64'(done_valid_o), 64'd1);
    chk("l1_status", 64'(done_status_o), 64'd0);
    chk("l1_ofm", 64'(done_ofm_cnt_o), 64'd14);
    chk("l1_ifm_final", 64'(ifm_addr_o), 64'h10700);
    chk("l1_wgt_final", 64'(wgt_addr_o), 64'h15000);
    tick();
    chk("l1_done_pulse", 64'(done_valid_o), 64'd0);
    chk("l1_ofm_hold", 64'(done_ofm_cnt_o), 64'd14);
    chk("l1_idle_busy", 64'(busy_o), 64'd0);

    // Overrun on IFM, underrun on weights
    set_cmd(2'd0, 2'd0, 32'h0, 32'h0);
    tick();
    cmd_valid_i = 1'b0;
    repeat (3) tick();
    run_kernel(7905, 13311, 0, 0, early);
    chk("ov_no_early", 64'(early), 64'd0);
    chk("ov_done_valid", 64'(done_valid_o), 64'd1);
    chk("ov_status", 64'(done_status_o), 64'b011);
    chk("ov_ifm_addr", 64'(ifm_addr_o), 64'd63240);
    chk("ov_wgt_addr", 64'(wgt_addr_o), 64'd53244);
    chk("ov_ofm", 64'(done_ofm_cnt_o), 64'd0);
    tick();

    // Watchdog timeout
    set_cmd(2'd2, 2'd1, 32'h2000, 32'h3000);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("to_cfg_ci", 64'(cfg_ci_o), 64'd2);
    chk("to_cfg_co", 64'(cfg_co_o), 64'd1);
    tick();
    chk("to_start", 64'(start_conv_o), 64'd1);
    tick();
    k = 0;
    while (!done_valid_o && k < 40) begin
      tick();
      k++;
    end
    chk("to_done_seen", 64'(done_valid_o), 64'd1);
    chk("to_cycles", 64'(k), 64'd16);
    chk("to_status", 64'(done_status_o), 64'b111);
    tick();
    ifm_read_i = 1'b1;
    wgt_read_i = 1'b1;
    tick();
    ifm_read_i = 1'b0;
    wgt_read_i = 1'b0;
    chk("idle_ifm_ignored", 64'(ifm_addr_o), 64'h2000);
    chk("idle_wgt_ignored", 64'(wgt_addr_o), 64'h3000);

    // Back-to-back with full FIFO
    set_cmd(2'd1, 2'd0, 32'h10000, 32'h20000);
    tick();
    cmd_valid_i = 1'b0;
    tick();
    chk("bb_a_cfg_ci", 64'(cfg_ci_o), 64'd1);
    tick();
    tick();
    set_cmd(2'd3, 2'd3, 32'h40000, 32'h50000);
    tick();
    chk("bb_ready_one", 64'(cmd_ready_o), 64'd1);
    set_cmd(2'd2, 2'd1, 32'h44000, 32'h54000);
    tick();
    chk("bb_ready_full", 64'(cmd_ready_o), 64'd0);
    set_cmd(2'd1, 2'd1, 32'h60000, 32'h70000);
    tick();
    chk("bb_ready_held", 64'(cmd_ready_o), 64'd0);
    run_kernel(15808, 26624, 0, 0, early);
    chk("bb_a_no_early", 64'(early), 64'd0);
    chk("bb_a_done", 64'(done_valid_o), 64'd1);
    chk("bb_a_status", 64'(done_status_o), 64'd0);
    chk("bb_a_ifm", 64'(ifm_addr_o), 64'h2EE00);
    chk("bb_a_wgt", 64'(wgt_addr_o), 64'h3A000);
    chk("bb_ready_done", 64'(cmd_ready_o), 64'd0);
    tick();
    chk("bb_n1_done_low", 64'(done_valid_o), 64'd0);
    chk("bb_n1_cfg_hold", 64'(cfg_ci_o), 64'd1);
    chk("bb_n1_ready", 64'(cmd_ready_o), 64'd0);
    tick();
    chk("bb_b_cfg_ci", 64'(cfg_ci_o), 64'd3);
    chk("bb_b_cfg_co", 64'(cfg_co_o), 64'd3);
    chk("bb_b_ifm_base", 64'(ifm_addr_o), 64'h40000);
    chk("bb_ready_after_pop", 64'(cmd_ready_o), 64'd1);
    tick();
    cmd_valid_i = 1'b0;
    chk("bb_d_accepted", 64'(cmd_ready_o), 64'd0);
    chk("bb_b_start", 64'(start_conv_o), 64'd1);
    tick();

    // Reset in the middle of layer B with descriptors queued
    ifm_read_i = 1'b1;
    wgt_read_i = 1'b1;
    repeat (100) tick();
    ifm_read_i = 1'b0;
    wgt_read_i = 1'b0;
    chk("mr_ifm_100", 64'(ifm_addr_o), 64'h40320);
    chk("mr_wgt_100", 64'(wgt_addr_o), 64'h50190);
    rst_n = 1'b0;
    #1;
    chk("mr_ifm_zero", 64'(ifm_addr_o), 64'd0);
    chk("mr_cfg_zero", 64'(cfg_ci_o), 64'd0);
    chk("mr_busy_zero", 64'(busy_o), 64'd0);
    chk("mr_ready_zero", 64'(cmd_ready_o), 64'd0);
    tick();
    tick();
    chk("mr_no_done", 64'(done_valid_o), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("mr_ready_back", 64'(cmd_ready_o), 64'd1);
    chk("mr_busy_idle", 64'(busy_o), 64'd0);
    tick();
    tick();
    chk("mr_queue_flushed", 64'(busy_o), 64'd0);
    chk("mr_no_start", 64'(start_conv_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
